// File: rtl/ingress_ram_arbiter_if.sv
// ingress_ram_arbiter_if
// Bundles the per-port FWFT ingress streams, the egress free pointers, the
// published commit pointers and the SRAM write stream of the ingress RAM
// arbiter.
//   master : the surroundings (ingress CDC buffers, egress, FEC stage)
//   slave  : the arbiter itself
// Signals (per port g, packed with port g at the lowest index):
//   port_rd_avail/en/last [NUM_PORTS], port_rd_data [NUM_PORTS*128],
//   port_rd_bytes [NUM_PORTS*5], port_free_ptr/commit_ptr [NUM_PORTS*PTR_BITS],
//   ram_wr_en, ram_wr_addr[17:0], ram_wr_data[143:0], drop_pulse, drop_count[31:0]
interface ingress_ram_arbiter_if #(
  parameter int NUM_PORTS = 15,
  parameter int PTR_BITS  = 14
);
  logic [NUM_PORTS-1:0]          port_rd_avail;
  logic [NUM_PORTS-1:0]          port_rd_en;
  logic [NUM_PORTS*128-1:0]      port_rd_data;
  logic [NUM_PORTS-1:0]          port_rd_last;
  logic [NUM_PORTS*5-1:0]        port_rd_bytes;
  logic [NUM_PORTS*PTR_BITS-1:0] port_free_ptr;
  logic [NUM_PORTS*PTR_BITS-1:0] port_commit_ptr;
  logic                          ram_wr_en;
  logic [17:0]                   ram_wr_addr;
  logic [143:0]                  ram_wr_data;
  logic                          drop_pulse;
  logic [31:0]                   drop_count;

  modport master (
    output port_rd_avail, port_rd_data, port_rd_last, port_rd_bytes, port_free_ptr,
    input  port_rd_en, port_commit_ptr, ram_wr_en, ram_wr_addr, ram_wr_data,
    input  drop_pulse, drop_count
  );

  modport slave (
    input  port_rd_avail, port_rd_data, port_rd_last, port_rd_bytes, port_free_ptr,
    output port_rd_en, port_commit_ptr, ram_wr_en, ram_wr_addr, ram_wr_data,
    output drop_pulse, drop_count
  );
endinterface

// File: rtl/ingress_ram_arbiter.sv
// ingress_ram_arbiter
// Round-robin arbiter that merges up to 16 per-port 128-bit FWFT streams into
// one SRAM write stream, keeping a ring buffer per port in QDR-II+. Each port
// has a write pointer and a commit pointer; commit pointers move only on a
// completed frame. Frames that would overflow their ring are dropped whole.
// Ports:
//   clk_ram_ctl : SRAM controller clock (only clock)
//   rst_n       : asynchronous active-low reset, released synchronously
//   bus         : ingress_ram_arbiter_if.slave (ingress streams, free/commit
//                 pointers, SRAM write stream, drop reporting)
// Timing: a word popped in cycle N is presented on ram_wr_* in cycle N+1.
module ingress_ram_arbiter #(
  parameter int NUM_PORTS   = 15,
  parameter int PTR_BITS    = 14,
  parameter int BURST_WORDS = 8
) (
  input  logic                 clk_ram_ctl,
  input  logic                 rst_n,
  ingress_ram_arbiter_if.slave bus
);
  localparam int BEAT_W = $clog2(BURST_WORDS + 1);

  typedef enum logic [0:0] {IDLE = 1'b0, GRANT = 1'b1} state_e;

  // Reset synchronizer: assertion is immediate, release waits two clocks.
  logic [1:0] rst_pipe_q;
  logic       rst_core_n;

  always_ff @(posedge clk_ram_ctl or negedge rst_n) begin
    if (!rst_n) rst_pipe_q <= 2'b00;
    else        rst_pipe_q <= {rst_pipe_q[0], 1'b1};
  end

  assign rst_core_n = rst_pipe_q[1];

  state_e                             state_q, state_d;
  logic [3:0]                         grant_q, grant_d;
  logic [3:0]                         last_grant_q, last_grant_d;
  logic [BEAT_W-1:0]                  beat_q, beat_d;
  logic [NUM_PORTS-1:0][PTR_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [NUM_PORTS-1:0][PTR_BITS-1:0] commit_ptr_q, commit_ptr_d;
  logic [NUM_PORTS-1:0]               in_frame_q, in_frame_d;
  logic [NUM_PORTS-1:0]               drop_q, drop_d;
  logic                               ram_wr_en_q, ram_wr_en_d;
  logic [17:0]                        ram_wr_addr_q, ram_wr_addr_d;
  logic [143:0]                       ram_wr_data_q, ram_wr_data_d;
  logic                               drop_pulse_q, drop_pulse_d;
  logic [31:0]                        drop_count_q, drop_count_d;

  logic [NUM_PORTS-1:0] rd_en;
  logic                 found;
  logic [3:0]           sel;
  logic [3:0]           cand;
  int                   gi;
  logic                 pop;
  logic                 w_last;
  logic [4:0]           w_bytes;
  logic [127:0]         w_data;
  logic [PTR_BITS-1:0]  free_ptr;
  logic [PTR_BITS-1:0]  nxt_ptr;
  logic                 full;

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_grant_d  = last_grant_q;
    beat_d        = beat_q;
    wr_ptr_d      = wr_ptr_q;
    commit_ptr_d  = commit_ptr_q;
    in_frame_d    = in_frame_q;
    drop_d        = drop_q;
    ram_wr_en_d   = 1'b0;
    ram_wr_addr_d = ram_wr_addr_q;
    ram_wr_data_d = ram_wr_data_q;
    drop_pulse_d  = 1'b0;
    drop_count_d  = drop_count_q;
    rd_en         = '0;
    found         = 1'b0;
    sel           = '0;
    cand          = '0;
    pop           = 1'b0;

    gi       = int'(grant_q);
    w_last   = bus.port_rd_last[grant_q];
    // Byte count is only meaningful on the last word; full words carry 16.
    w_bytes  = w_last ? bus.port_rd_bytes[gi*5 +: 5] : 5'd16;
    w_data   = bus.port_rd_data[gi*128 +: 128];
    free_ptr = bus.port_free_ptr[gi*PTR_BITS +: PTR_BITS];
    nxt_ptr  = wr_ptr_q[grant_q] + 1'b1;
    // One slot is kept empty so that wr_ptr == free_ptr always means empty.
    full     = (nxt_ptr == free_ptr);

    case (state_q)
      IDLE: begin
        // Rotating priority: start just after the previously served port.
        for (int i = 0; i < NUM_PORTS; i++) begin
          cand = 4'((int'(last_grant_q) + 1 + i) % NUM_PORTS);
          if (!found && bus.port_rd_avail[cand]) begin
            found = 1'b1;
            sel   = cand;
          end
        end
        if (found) begin
          state_d = GRANT;
          grant_d = sel;
          beat_d  = '0;
        end
      end
      GRANT: begin
        pop            = bus.port_rd_avail[grant_q];
        rd_en[grant_q] = pop;
        if (pop) begin
          beat_d = beat_q + 1'b1;
          if (drop_q[grant_q] || full) begin
            // Discard the rest of the frame and rewind to the last commit so
            // the partial frame never becomes visible to egress.
            wr_ptr_d[grant_q]   = commit_ptr_q[grant_q];
            drop_d[grant_q]     = !w_last;
            in_frame_d[grant_q] = !w_last;
            if (w_last) begin
              drop_pulse_d = 1'b1;
              if (drop_count_q != 32'hFFFF_FFFF) drop_count_d = drop_count_q + 32'd1;
            end
          end else begin
            ram_wr_en_d         = 1'b1;
            ram_wr_addr_d       = 18'({grant_q, wr_ptr_q[grant_q]});
            ram_wr_data_d       = {grant_q, !in_frame_q[grant_q], w_last, w_bytes, 5'd0, w_data};
            wr_ptr_d[grant_q]   = nxt_ptr;
            in_frame_d[grant_q] = !w_last;
            if (w_last) commit_ptr_d[grant_q] = nxt_ptr;
          end
        end
        if (!pop || w_last || (int'(beat_q) + 1 >= BURST_WORDS)) begin
          state_d      = IDLE;
          last_grant_d = grant_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_ram_ctl or negedge rst_core_n) begin
    if (!rst_core_n) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      last_grant_q  <= '0;
      beat_q        <= '0;
      wr_ptr_q      <= '0;
      commit_ptr_q  <= '0;
      in_frame_q    <= '0;
      drop_q        <= '0;
      ram_wr_en_q   <= 1'b0;
      ram_wr_addr_q <= '0;
      ram_wr_data_q <= '0;
      drop_pulse_q  <= 1'b0;
      drop_count_q  <= '0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      last_grant_q  <= last_grant_d;
      beat_q        <= beat_d;
      wr_ptr_q      <= wr_ptr_d;
      commit_ptr_q  <= commit_ptr_d;
      in_frame_q    <= in_frame_d;
      drop_q        <= drop_d;
      ram_wr_en_q   <= ram_wr_en_d;
      ram_wr_addr_q <= ram_wr_addr_d;
      ram_wr_data_q <= ram_wr_data_d;
      drop_pulse_q  <= drop_pulse_d;
      drop_count_q  <= drop_count_d;
    end
  end

  assign bus.port_rd_en      = rd_en;
  assign bus.port_commit_ptr = commit_ptr_q;
  assign bus.ram_wr_en       = ram_wr_en_q;
  assign bus.ram_wr_addr     = ram_wr_addr_q;
  assign bus.ram_wr_data     = ram_wr_data_q;
  assign bus.drop_pulse      = drop_pulse_q;
  assign bus.drop_count      = drop_count_q;

endmodule

// File: tb/tb_ingress_ram_arbiter.sv
// tb_ingress_ram_arbiter
// Two arbiters share clock and reset: dut_a with 14-bit ring pointers and
// dut_b with 4-bit ring pointers (small rings for overflow/wrap cases).
// Per-port FWFT sources are queues; expected SRAM writes are queued when the
// stimulus is built and compared as ram_wr_en is seen.
module tb_ingress_ram_arbiter;
  localparam int NP = 15;
  localparam int LIMIT = 400;

  typedef struct {
    logic [127:0] data;
    logic         last;
    logic [4:0]   bytes;
  } word_t;

  typedef struct {
    logic [17:0]  addr;
    logic [143:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ingress_ram_arbiter_if #(.NUM_PORTS(NP), .PTR_BITS(14)) bus_a ();
  ingress_ram_arbiter_if #(.NUM_PORTS(NP), .PTR_BITS(4))  bus_b ();

  ingress_ram_arbiter #(.NUM_PORTS(NP), .PTR_BITS(14), .BURST_WORDS(8)) dut_a (
    .clk_ram_ctl(clk), .rst_n(rst_n), .bus(bus_a.slave));
  ingress_ram_arbiter #(.NUM_PORTS(NP), .PTR_BITS(4), .BURST_WORDS(8)) dut_b (
    .clk_ram_ctl(clk), .rst_n(rst_n), .bus(bus_b.slave));

  word_t src_a [NP][$];
  word_t src_b [NP][$];
  exp_t  exp_a [$];
  exp_t  exp_b [$];

  int errors = 0;
  int checks = 0;
  int wr_seen_a = 0;
  int wr_seen_b = 0;
  int pulse_b = 0;
  logic [NP-1:0] mask_a, mask_b;
  exp_t mon_ea, mon_eb;

  function automatic logic [15:0] mk_tag(input int port, input bit start, input bit last, input int bytes);
    logic [3:0] p;
    logic [4:0] b;
    p = 4'(port);
    b = 5'(bytes);
    return {p, start, last, b, 5'd0};
  endfunction

  function automatic exp_t mk_exp(input bit is_b, input int port, input int ptr, input bit start, input word_t w);
    exp_t e;
    e.addr = is_b ? 18'(port * 16 + ptr) : 18'(port * 16384 + ptr);
    e.data = {mk_tag(port, start, w.last, w.last ? int'(w.bytes) : 16), w.data};
    return e;
  endfunction

  task automatic make_word(input bit last, input int bytes, output word_t w);
    w.data  = {$urandom, $urandom, $urandom, $urandom};
    w.last  = last;
    w.bytes = 5'(bytes);
  endtask

  function automatic bit src_idle();
    for (int g = 0; g < NP; g++)
      if (src_a[g].size() != 0 || src_b[g].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic refresh();
    for (int g = 0; g < NP; g++) begin
      bus_a.port_rd_avail[g] = (src_a[g].size() != 0);
      if (src_a[g].size() != 0) begin
        bus_a.port_rd_data[g*128 +: 128] = src_a[g][0].data;
        bus_a.port_rd_last[g]            = src_a[g][0].last;
        bus_a.port_rd_bytes[g*5 +: 5]    = src_a[g][0].bytes;
      end
      bus_b.port_rd_avail[g] = (src_b[g].size() != 0);
      if (src_b[g].size() != 0) begin
        bus_b.port_rd_data[g*128 +: 128] = src_b[g][0].data;
        bus_b.port_rd_last[g]            = src_b[g][0].last;
        bus_b.port_rd_bytes[g*5 +: 5]    = src_b[g][0].bytes;
      end
    end
  endtask

  // FWFT source model: rd_en sampled just before the edge, pop just after.
  initial begin
    mask_a = '0;
    mask_b = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int g = 0; g < NP; g++) begin
        if (mask_a[g] && src_a[g].size() != 0) void'(src_a[g].pop_front());
        if (mask_b[g] && src_b[g].size() != 0) void'(src_b[g].pop_front());
      end
      refresh();
      @(negedge clk);
      #2;
      refresh();
      #2;
      mask_a = bus_a.port_rd_en;
      mask_b = bus_b.port_rd_en;
    end
  end

  // Scoreboard: every SRAM write must match the oldest expected entry.
  always @(negedge clk) begin
    if (bus_a.ram_wr_en === 1'b1) begin
      wr_seen_a++;
      checks++;
      if (exp_a.size() == 0) begin
        errors++;
        $display("FAIL wr_a_extra: got addr=%h data=%h, required no write", bus_a.ram_wr_addr, bus_a.ram_wr_data);
      end else begin
        mon_ea = exp_a.pop_front();
        if (bus_a.ram_wr_addr !== mon_ea.addr || bus_a.ram_wr_data !== mon_ea.data) begin
          errors++;
          $display("FAIL wr_a: got addr=%h data=%h, required addr=%h data=%h",
                   bus_a.ram_wr_addr, bus_a.ram_wr_data, mon_ea.addr, mon_ea.data);
        end
      end
    end
    if (bus_b.ram_wr_en === 1'b1) begin
      wr_seen_b++;
      checks++;
      if (exp_b.size() == 0) begin
        errors++;
        $display("FAIL wr_b_extra: got addr=%h data=%h, required no write", bus_b.ram_wr_addr, bus_b.ram_wr_data);
      end else begin
        mon_eb = exp_b.pop_front();
        if (bus_b.ram_wr_addr !== mon_eb.addr || bus_b.ram_wr_data !== mon_eb.data) begin
          errors++;
          $display("FAIL wr_b: got addr=%h data=%h, required addr=%h data=%h",
                   bus_b.ram_wr_addr, bus_b.ram_wr_data, mon_eb.addr, mon_eb.data);
        end
      end
    end
    if (bus_b.drop_pulse === 1'b1) pulse_b++;
  end

  task automatic drain(output int cyc);
    cyc = 0;
    while ((!src_idle() || exp_a.size() != 0 || exp_b.size() != 0) && cyc < LIMIT) begin
      @(negedge clk);
      cyc++;
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (bus_a.ram_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en_a: got %b, required 0", bus_a.ram_wr_en); end
    checks++; if (bus_a.ram_wr_addr !== 18'd0) begin errors++; $display("FAIL reset_addr_a: got %h, required 0", bus_a.ram_wr_addr); end
    checks++; if (bus_a.ram_wr_data !== 144'd0) begin errors++; $display("FAIL reset_data_a: got %h, required 0", bus_a.ram_wr_data); end
    checks++; if (bus_a.drop_pulse !== 1'b0) begin errors++; $display("FAIL reset_pulse_a: got %b, required 0", bus_a.drop_pulse); end
    checks++; if (bus_a.drop_count !== 32'd0) begin errors++; $display("FAIL reset_count_a: got %0d, required 0", bus_a.drop_count); end
    checks++; if (bus_a.port_commit_ptr !== '0) begin errors++; $display("FAIL reset_commit_a: got %h, required 0", bus_a.port_commit_ptr); end
    checks++; if (bus_a.port_rd_en !== '0) begin errors++; $display("FAIL reset_rd_en_a: got %h, required 0", bus_a.port_rd_en); end
    checks++; if (bus_b.ram_wr_en !== 1'b0 || bus_b.drop_count !== 32'd0 || bus_b.port_commit_ptr !== '0) begin
      errors++; $display("FAIL reset_b: got wr_en=%b count=%0d commit=%h, required all 0", bus_b.ram_wr_en, bus_b.drop_count, bus_b.port_commit_ptr);
    end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_single_frame();
    word_t w;
    int cyc;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      make_word(i == 2, (i == 2) ? 5 : 3, w);
      exp_a.push_back(mk_exp(1'b0, 0, i, i == 0, w));
      src_a[0].push_back(w);
    end
    drain(cyc);
    checks++; if (cyc >= LIMIT) begin errors++; $display("FAIL single_drain: got timeout after %0d cycles, required completion", cyc); end
    checks++; if (bus_a.port_commit_ptr[0 +: 14] !== 14'd3) begin
      errors++; $display("FAIL single_commit: got %0d, required 3", bus_a.port_commit_ptr[0 +: 14]);
    end
  endtask

  // Port 4 served last leaves the rotation pointer above port 2 and below
  // port 5, so port 5 must win over port 2.
  task automatic test_round_robin();
    word_t w2, w4, w5;
    int cyc;
    @(negedge clk);
    make_word(1'b1, 4, w4);
    exp_a.push_back(mk_exp(1'b0, 4, 0, 1'b1, w4));
    src_a[4].push_back(w4);
    drain(cyc);
    checks++; if (cyc >= LIMIT) begin errors++; $display("FAIL rr_prelude_drain: got timeout after %0d cycles, required completion", cyc); end
    make_word(1'b1, 12, w2);
    make_word(1'b1, 1, w5);
    exp_a.push_back('{addr: 18'h14000, data: {mk_tag(5, 1'b1, 1'b1, 1), w5.data}});
    exp_a.push_back('{addr: 18'h08000, data: {mk_tag(2, 1'b1, 1'b1, 12), w2.data}});
    src_a[2].push_back(w2);
    src_a[5].push_back(w5);
    drain(cyc);
    checks++; if (cyc >= LIMIT) begin errors++; $display("FAIL rr_drain: got timeout after %0d cycles, required completion", cyc); end
    checks++; if (bus_a.port_commit_ptr[2*14 +: 14] !== 14'd1 || bus_a.port_commit_ptr[5*14 +: 14] !== 14'd1) begin
      errors++; $display("FAIL rr_commit: got p2=%0d p5=%0d, required 1 and 1",
                         bus_a.port_commit_ptr[2*14 +: 14], bus_a.port_commit_ptr[5*14 +: 14]);
    end
  endtask

  task automatic test_burst_split();
    word_t p1 [20];
    word_t p3;
    int base, n, cyc;
    @(negedge clk);
    for (int i = 0; i < 20; i++) make_word(i == 19, (i == 19) ? 11 : 7, p1[i]);
    make_word(1'b1, 2, p3);
    for (int i = 0; i < 8; i++) exp_a.push_back(mk_exp(1'b0, 1, i, i == 0, p1[i]));
    exp_a.push_back(mk_exp(1'b0, 3, 0, 1'b1, p3));
    for (int i = 8; i < 20; i++) exp_a.push_back(mk_exp(1'b0, 1, i, 1'b0, p1[i]));
    base = wr_seen_a;
    for (int i = 0; i < 20; i++) src_a[1].push_back(p1[i]);
    n = 0;
    while (wr_seen_a == base && n < LIMIT) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++; if (n >= LIMIT) begin errors++; $display("FAIL burst_first_word: got no write in %0d cycles, required one", n); end
    src_a[3].push_back(p3);
    drain(cyc);
    checks++; if (cyc >= LIMIT) begin errors++; $display("FAIL burst_drain: got timeout after %0d cycles, required completion", cyc); end
    checks++; if (bus_a.port_commit_ptr[1*14 +: 14] !== 14'd20 || bus_a.port_commit_ptr[3*14 +: 14] !== 14'd1) begin
      errors++; $display("FAIL burst_commit: got p1=%0d p3=%0d, required 20 and 1",
                         bus_a.port_commit_ptr[1*14 +: 14], bus_a.port_commit_ptr[3*14 +: 14]);
    end
  endtask

  task automatic test_overflow_drop();
    word_t w;
    int p0, cyc;
    @(negedge clk);
    bus_b.port_free_ptr[0 +: 4] = 4'd0;
    p0 = pulse_b;
    for (int i = 0; i < 20; i++) begin
      make_word(i == 19, (i == 19) ? 7 : 3, w);
      if (i < 15) exp_b.push_back(mk_exp(1'b1, 0, i, i == 0, w));
      src_b[0].push_back(w);
    end
    drain(cyc);
    checks++; if (cyc >= LIMIT) begin errors++; $display("FAIL drop_drain: got timeout after %0d cycles, required completion", cyc); end
    checks++; if (pulse_b - p0 != 1) begin errors++; $display("FAIL drop_pulse: got %0d pulses, required 1", pulse_b - p0); end
    checks++; if (bus_b.drop_count !== 32'd1) begin errors++; $display("FAIL drop_count: got %0d, required 1", bus_b.drop_count); end
    checks++; if (bus_b.port_commit_ptr[0 +: 4] !== 4'd0) begin
      errors++; $display("FAIL drop_commit: got %0d, required 0", bus_b.port_commit_ptr[0 +: 4]);
    end
  endtask

  task automatic test_wrap();
    word_t w;
    int cyc;
    @(negedge clk);
    // Fill to ptr 15; this frame also proves the drop rewound wr_ptr to 0.
    for (int i = 0; i < 15; i++) begin
      make_word(i == 14, (i == 14) ? 16 : 9, w);
      exp_b.push_back(mk_exp(1'b1, 0, i, i == 0, w));
      src_b[0].push_back(w);
    end
    drain(cyc);
    checks++; if (cyc >= LIMIT) begin errors++; $display("FAIL wrap_fill_drain: got timeout after %0d cycles, required completion", cyc); end
    checks++; if (bus_b.port_commit_ptr[0 +: 4] !== 4'd15) begin
      errors++; $display("FAIL wrap_fill_commit: got %0d, required 15", bus_b.port_commit_ptr[0 +: 4]);
    end
    bus_b.port_free_ptr[0 +: 4] = 4'd8;
    for (int i = 0; i < 3; i++) begin
      make_word(i == 2, (i == 2) ? 6 : 1, w);
      exp_b.push_back(mk_exp(1'b1, 0, (15 + i) % 16, i == 0, w));
      src_b[0].push_back(w);
    end
    drain(cyc);
    checks++; if (cyc >= LIMIT) begin errors++; $display("FAIL wrap_drain: got timeout after %0d cycles, required completion", cyc); end
    checks++; if (bus_b.port_commit_ptr[0 +: 4] !== 4'd2) begin
      errors++; $display("FAIL wrap_commit: got %0d, required 2", bus_b.port_commit_ptr[0 +: 4]);
    end
    checks++; if (bus_b.drop_count !== 32'd1) begin errors++; $display("FAIL wrap_count: got %0d, required 1", bus_b.drop_count); end
  endtask

  task automatic test_reset_mid_frame();
    word_t w;
    int base, n, cyc;
    @(negedge clk);
    base = wr_seen_a;
    for (int i = 0; i < 4; i++) begin
      make_word(i == 3, (i == 3) ? 8 : 2, w);
      if (i < 2) exp_a.push_back(mk_exp(1'b0, 0, 3 + i, i == 0, w));
      src_a[0].push_back(w);
    end
    n = 0;
    while (wr_seen_a < base + 2 && n < LIMIT) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++; if (n >= LIMIT) begin errors++; $display("FAIL rstmid_two_words: got %0d writes, required 2", wr_seen_a - base); end
    rst_n = 1'b0;
    #1;
    checks++; if (bus_a.ram_wr_en !== 1'b0 || bus_a.ram_wr_addr !== 18'd0 || bus_a.ram_wr_data !== 144'd0) begin
      errors++; $display("FAIL rstmid_wr: got en=%b addr=%h, required all 0", bus_a.ram_wr_en, bus_a.ram_wr_addr);
    end
    checks++; if (bus_a.port_commit_ptr !== '0 || bus_a.port_rd_en !== '0) begin
      errors++; $display("FAIL rstmid_ptr: got commit=%h rd_en=%h, required 0", bus_a.port_commit_ptr, bus_a.port_rd_en);
    end
    checks++; if (bus_b.drop_count !== 32'd0 || bus_a.drop_pulse !== 1'b0) begin
      errors++; $display("FAIL rstmid_drop: got count_b=%0d pulse_a=%b, required 0", bus_b.drop_count, bus_a.drop_pulse);
    end
    checks++; if (exp_a.size() != 0) begin errors++; $display("FAIL rstmid_pending: got %0d expected writes left, required 0", exp_a.size()); end
    for (int g = 0; g < NP; g++) begin
      src_a[g].delete();
      src_b[g].delete();
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    make_word(1'b1, 9, w);
    exp_a.push_back(mk_exp(1'b0, 0, 0, 1'b1, w));
    src_a[0].push_back(w);
    drain(cyc);
    checks++; if (cyc >= LIMIT) begin errors++; $display("FAIL rstmid_drain: got timeout after %0d cycles, required completion", cyc); end
    checks++; if (bus_a.port_commit_ptr[0 +: 14] !== 14'd1) begin
      errors++; $display("FAIL rstmid_commit: got %0d, required 1", bus_a.port_commit_ptr[0 +: 14]);
    end
  endtask

  initial begin
    bus_a.port_rd_avail = '0; bus_a.port_rd_data = '0; bus_a.port_rd_last = '0;
    bus_a.port_rd_bytes = '0; bus_a.port_free_ptr = '0;
    bus_b.port_rd_avail = '0; bus_b.port_rd_data = '0; bus_b.port_rd_last = '0;
    bus_b.port_rd_bytes = '0; bus_b.port_free_ptr = '0;
    test_reset();
    test_single_frame();
    test_round_robin();
    test_burst_split();
    test_overflow_drop();
    test_wrap();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no completion by 400000, required summary");
    $fatal(1, "watchdog expired");
  end
endmodule
